// File: rtl/xlr8_xb_arb_if.sv
// Requester and shared-target signal bundle for the xlr8_xb_arb crossbar arbiter.
// Handshake: requester i raises req[i] with adr/we/wdata stable and holds it until done[i] pulses.
// gnt[i] marks ownership while the access waits for the target. rdata is valid only while done[i]=1.
interface xlr8_xb_arb_if;
    logic [1:0] req;
    logic [1:0] we;
    logic [7:0] adr0;
    logic [7:0] adr1;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic [1:0] gnt;
    logic [1:0] done;
    logic [7:0] rdata;
    logic [7:0] tgt_adr;
    logic [7:0] tgt_wdata;
    logic [7:0] tgt_rdata;
    logic       tgt_we;
    logic       tgt_re;

    modport slave (
        input  req, we, adr0, adr1, wdata0, wdata1, tgt_rdata,
        output gnt, done, rdata, tgt_adr, tgt_we, tgt_re, tgt_wdata
    );

    modport master (
        output req, we, adr0, adr1, wdata0, wdata1, tgt_rdata,
        input  gnt, done, rdata, tgt_adr, tgt_we, tgt_re, tgt_wdata
    );
endinterface

// File: rtl/xlr8_xb_arb.sv
// Two-requester arbiter sharing one 8-bit target with the AVR data bus; AVR accesses always win.
// CTRL/STAT registers live on the AVR bus; a three-state FSM sequences hardware transactions.
module xlr8_xb_arb #(
    parameter logic [7:0] CTRL_ADDR = 8'h00,
    parameter logic [7:0] STAT_ADDR = 8'h00
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clken,
    input  logic [7:0]   ramadr,
    input  logic         ramre,
    input  logic         ramwe,
    input  logic         dm_sel,
    input  logic [7:0]   dbus_in,
    output logic [7:0]   dbus_out,
    output logic         io_out_en,
    xlr8_xb_arb_if.slave bus,
    output logic [1:0]   state_dbg
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic       ctrl_en;
    logic       ctrl_pri;
    logic       winner;
    logic       lastwin;
    logic       starve;
    logic [3:0] stall_cnt;
    logic [7:0] rdata_q;

    logic       ctrl_hit;
    logic       stat_hit;
    logic       avr_acc;
    logic       ctrl_wr;
    logic       pick;
    logic       win_req;
    logic       win_we;
    logic [7:0] win_adr;
    logic [7:0] win_wdata;
    logic       issue;
    logic       stall_inc;

    // With equal addresses CTRL decodes first, so STAT is only reachable at a distinct address.
    assign ctrl_hit  = (ramadr == CTRL_ADDR);
    assign stat_hit  = (ramadr == STAT_ADDR) && !ctrl_hit;
    assign avr_acc   = dm_sel && (ramre || ramwe) && !ctrl_hit && (ramadr != STAT_ADDR);
    assign ctrl_wr   = clken && dm_sel && ramwe && ctrl_hit;

    assign pick      = (&bus.req) ? (ctrl_pri ? 1'b0 : !lastwin) : bus.req[1];
    assign win_req   = winner ? bus.req[1] : bus.req[0];
    assign win_we    = winner ? bus.we[1]  : bus.we[0];
    assign win_adr   = winner ? bus.adr1   : bus.adr0;
    assign win_wdata = winner ? bus.wdata1 : bus.wdata0;

    // Gating with rstn keeps the target quiet while a reset abandons an in-flight access.
    assign issue     = rstn && (state == ST_BUSY) && win_req && clken && !avr_acc;
    assign stall_inc = (state == ST_BUSY) && win_req && clken && avr_acc;

    assign state_dbg = state;
    assign bus.rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (ctrl_en && (|bus.req)) state_nxt = ST_BUSY;
            ST_BUSY: begin
                if (!win_req) begin
                    state_nxt = ST_IDLE;
                end else if (issue) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.gnt       = 2'b00;
        bus.done      = 2'b00;
        bus.tgt_adr   = 8'h00;
        bus.tgt_we    = 1'b0;
        bus.tgt_re    = 1'b0;
        bus.tgt_wdata = 8'h00;
        case (state)
            ST_BUSY: bus.gnt  = winner ? 2'b10 : 2'b01;
            ST_DONE: bus.done = winner ? 2'b10 : 2'b01;
            default: ;
        endcase
        if (avr_acc) begin
            bus.tgt_adr   = ramadr;
            bus.tgt_we    = ramwe;
            bus.tgt_re    = ramre;
            bus.tgt_wdata = dbus_in;
        end else if (issue) begin
            bus.tgt_adr   = win_adr;
            bus.tgt_we    = win_we;
            bus.tgt_re    = !win_we;
            bus.tgt_wdata = win_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ctrl_en   <= 1'b0;
            ctrl_pri  <= 1'b0;
            winner    <= 1'b0;
            lastwin   <= 1'b1;
            starve    <= 1'b0;
            stall_cnt <= 4'd0;
            rdata_q   <= 8'h00;
        end else begin
            if (ctrl_wr) begin
                ctrl_en  <= dbus_in[0];
                ctrl_pri <= dbus_in[1];
            end
            if ((state == ST_IDLE) && ctrl_en && (|bus.req)) winner <= pick;
            if (state == ST_DONE) lastwin <= winner;
            if (issue) begin
                stall_cnt <= 4'd0;
            end else if (stall_inc && (stall_cnt != 4'hF)) begin
                stall_cnt <= stall_cnt + 4'd1;
            end
            if (ctrl_wr) begin
                starve <= 1'b0;
            end else if (stall_inc && (stall_cnt >= 4'd14)) begin
                starve <= 1'b1;
            end
            if (issue && !win_we) rdata_q <= bus.tgt_rdata;
        end
    end

    always_comb begin
        dbus_out  = 8'h00;
        io_out_en = 1'b0;
        if (dm_sel && ramre) begin
            io_out_en = 1'b1;
            if (ctrl_hit) begin
                dbus_out = {6'b0, ctrl_pri, ctrl_en};
            end else if (stat_hit) begin
                dbus_out = {stall_cnt, 1'b0, starve, lastwin, state != ST_IDLE};
            end else begin
                dbus_out = bus.tgt_rdata;
            end
        end
    end
endmodule

// File: tb/tb_xlr8_xb_arb.sv
// Bench for xlr8_xb_arb: directed arbitration, stall, status and reset scenarios, then randomized
// requester/AVR traffic against a target memory and a transaction-level expected model.
module tb_xlr8_xb_arb;
    localparam logic [7:0] CTRL_A = 8'hF0;
    localparam logic [7:0] STAT_A = 8'hF1;

    logic       clk;
    logic       rstn;
    logic       clken;
    logic [7:0] ramadr;
    logic       ramre;
    logic       ramwe;
    logic       dm_sel;
    logic [7:0] dbus_in;
    logic [7:0] dbus_out;
    logic       io_out_en;
    logic [1:0] state_dbg;

    logic       req_d   [2];
    logic       we_d    [2];
    logic [7:0] adr_d   [2];
    logic [7:0] wdata_d [2];

    int tests;
    int fails;

    xlr8_xb_arb_if xif();
    assign xif.req    = {req_d[1], req_d[0]};
    assign xif.we     = {we_d[1], we_d[0]};
    assign xif.adr0   = adr_d[0];
    assign xif.adr1   = adr_d[1];
    assign xif.wdata0 = wdata_d[0];
    assign xif.wdata1 = wdata_d[1];

    xlr8_xb_arb #(.CTRL_ADDR(CTRL_A), .STAT_ADDR(STAT_A)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clken     (clken),
        .ramadr    (ramadr),
        .ramre     (ramre),
        .ramwe     (ramwe),
        .dm_sel    (dm_sel),
        .dbus_in   (dbus_in),
        .dbus_out  (dbus_out),
        .io_out_en (io_out_en),
        .bus       (xif),
        .state_dbg (state_dbg)
    );

    // ---- clock / reset ----
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---- target memory model ----
    logic [7:0] tmem [256];
    logic       tgt_init;
    always @(posedge clk) begin
        if (tgt_init) begin
            for (int i = 0; i < 256; i++) tmem[i] <= 8'(i) ^ 8'hA5;
        end else if (xif.tgt_we) begin
            tmem[xif.tgt_adr] <= xif.tgt_wdata;
        end
    end
    assign xif.tgt_rdata = tmem[xif.tgt_adr];

    // ---- reference model and scoreboard ----
    logic [7:0]  ref_mem [256];
    logic [16:0] exp_q0 [$];
    logic [16:0] exp_q1 [$];
    logic        exp_win_q [$];
    logic        last_idx;
    logic [7:0]  ctrl_model;
    bit          stop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input int act);
        tests++;
        fails++;
        $display("FAIL %s: actual %0d, required no event", name, act);
    endtask

    function automatic logic [16:0] make_exp(input logic w, input logic [7:0] a, input logic [7:0] d);
        if (w) ref_mem[a] = d;
        return {w, a, ref_mem[a]};
    endfunction

    initial begin
        logic [16:0] e;
        logic        idx;
        last_idx = 1'b1;
        forever begin
            @(negedge clk);
            if (xif.gnt != 2'b00) check("gnt_onehot", 32'($onehot(xif.gnt)), 1);
            if (xif.done != 2'b00) begin
                check("done_onehot", 32'($onehot(xif.done)), 1);
                check("gnt_low_in_done", 32'(xif.gnt), 0);
                idx = xif.done[1];
                if ((idx && exp_q1.size() == 0) || (!idx && exp_q0.size() == 0)) begin
                    fail_now("unexpected_done", int'(idx));
                end else begin
                    if (idx) e = exp_q1.pop_front();
                    else     e = exp_q0.pop_front();
                    if (e[16]) check($sformatf("wr_data_r%0d", idx), 32'(tmem[e[15:8]]), 32'(e[7:0]));
                    else       check($sformatf("rd_data_r%0d", idx), 32'(xif.rdata), 32'(e[7:0]));
                end
                if (exp_win_q.size() != 0) check("winner", 32'(idx), 32'(exp_win_q.pop_front()));
                last_idx = idx;
            end
        end
    end

    // ---- driver tasks ----
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic avr_idle();
        dm_sel  = 1'b0;
        ramre   = 1'b0;
        ramwe   = 1'b0;
        ramadr  = 8'h00;
        dbus_in = 8'h00;
    endtask

    task automatic avr_write(input logic [7:0] a, input logic [7:0] d);
        clken   = 1'b1;
        dm_sel  = 1'b1;
        ramwe   = 1'b1;
        ramadr  = a;
        dbus_in = d;
        tick();
        avr_idle();
    endtask

    task automatic avr_read_chk(input string name, input logic [7:0] a, input logic [7:0] d);
        dm_sel = 1'b1;
        ramre  = 1'b1;
        ramadr = a;
        @(negedge clk);
        check({name, "_data"}, 32'(dbus_out), 32'(d));
        check({name, "_oen"}, 32'(io_out_en), 1);
        tick();
        avr_idle();
    endtask

    task automatic wait_dones(input string name, input int n, input int budget);
        int seen;
        seen = 0;
        for (int c = 0; c < budget && seen < n; c++) begin
            @(negedge clk);
            if (xif.done != 2'b00) seen++;
        end
        check(name, 32'(seen), 32'(n));
    endtask

    task automatic set_req(input int i, input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        req_d[i]   = r;
        we_d[i]    = w;
        adr_d[i]   = a;
        wdata_d[i] = d;
    endtask

    task automatic req_driver(input int i, input int n);
        logic [7:0] a;
        logic [7:0] d;
        logic       w;
        bit         got;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(3, 1)) tick();
            a = 8'(i * 32 + $urandom_range(31, 0));
            w = 1'($urandom_range(1, 0));
            d = 8'($urandom_range(255, 0));
            if (i == 0) exp_q0.push_back(make_exp(w, a, d));
            else        exp_q1.push_back(make_exp(w, a, d));
            set_req(i, 1'b1, w, a, d);
            got = 0;
            for (int c = 0; c < 400 && !got; c++) begin
                @(negedge clk);
                if (xif.done[i]) got = 1;
            end
            check($sformatf("drv%0d_complete", i), 32'(got), 1);
            tick();
            req_d[i] = 1'b0;
        end
    endtask

    task automatic avr_random();
        logic [7:0] a;
        logic [7:0] d;
        int         r;
        while (!stop) begin
            avr_idle();
            clken = ($urandom_range(9, 0) != 0);
            r = $urandom_range(9, 0);
            a = 8'($urandom_range(8'hEF, 8'h80));
            d = 8'($urandom_range(255, 0));
            if (r < 2) begin
                dm_sel = 1'b1; ramre = 1'b1; ramadr = a;
            end else if (r < 4) begin
                dm_sel = 1'b1; ramwe = 1'b1; ramadr = a; dbus_in = d;
                ref_mem[a] = d;
            end else if (r == 4) begin
                clken = 1'b1; dm_sel = 1'b1; ramwe = 1'b1; ramadr = CTRL_A;
                dbus_in = d | 8'h01;
                ctrl_model = {6'b0, d[1], 1'b1};
            end else if (r == 5) begin
                dm_sel = 1'b1; ramre = 1'b1; ramadr = CTRL_A;
            end
            @(negedge clk);
            if (r < 4) begin
                check("fwd_adr", 32'(xif.tgt_adr), 32'(a));
                check("fwd_we", 32'(xif.tgt_we), 32'(r >= 2));
                check("fwd_re", 32'(xif.tgt_re), 32'(r < 2));
                if (r < 2) check("fwd_rdata", 32'(dbus_out), 32'(ref_mem[a]));
                else       check("fwd_wdata", 32'(xif.tgt_wdata), 32'(d));
            end else if (r == 5) begin
                check("ctrl_rd", 32'(dbus_out), 32'(ctrl_model));
            end
            tick();
        end
        avr_idle();
    endtask

    // ---- main sequence ----
    initial begin
        logic w;
        tests = 0;
        fails = 0;
        stop  = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hA5;
        for (int i = 0; i < 2; i++) set_req(i, 1'b0, 1'b0, 8'h00, 8'h00);
        avr_idle();
        rstn = 1'b0;
        clken = 1'b1;
        tgt_init = 1'b1;
        ctrl_model = 8'h00;
        tick();
        tgt_init = 1'b0;
        tick();
        @(negedge clk);
        check("rst_gnt", 32'(xif.gnt), 0);
        check("rst_done", 32'(xif.done), 0);
        check("rst_tgt_we_re", 32'({xif.tgt_we, xif.tgt_re}), 0);
        check("rst_tgt_adr_wdata", 32'({xif.tgt_adr, xif.tgt_wdata}), 0);
        check("rst_rdata", 32'(xif.rdata), 0);
        tick();
        rstn = 1'b1;
        avr_read_chk("rst_ctrl", CTRL_A, 8'h00);
        avr_read_chk("rst_stat", STAT_A, 8'h02);

        // single write from requester 0
        avr_write(CTRL_A, 8'h01);
        exp_q0.push_back(make_exp(1'b1, 8'h40, 8'h5A));
        exp_win_q.push_back(1'b0);
        set_req(0, 1'b1, 1'b1, 8'h40, 8'h5A);
        @(negedge clk);
        check("wr_idle_gnt", 32'(xif.gnt), 0);
        tick();
        @(negedge clk);
        check("wr_gnt", 32'(xif.gnt), 32'h1);
        check("wr_tgt_we", 32'({xif.tgt_we, xif.tgt_re}), 32'h2);
        check("wr_tgt_adr", 32'(xif.tgt_adr), 32'h40);
        check("wr_tgt_wdata", 32'(xif.tgt_wdata), 32'h5A);
        tick();
        @(negedge clk);
        check("wr_done", 32'(xif.done), 32'h1);
        check("wr_strobe_once", 32'(xif.tgt_we), 0);
        tick();
        req_d[0] = 1'b0;
        avr_read_chk("wr_stat", STAT_A, 8'h00);

        // round robin with both requesters reading
        w = !last_idx;
        for (int k = 0; k < 6; k++) begin
            exp_win_q.push_back(w);
            w = !w;
        end
        for (int k = 0; k < 3; k++) begin
            exp_q0.push_back(make_exp(1'b0, 8'h10, 8'h00));
            exp_q1.push_back(make_exp(1'b0, 8'h30, 8'h00));
        end
        set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
        set_req(1, 1'b1, 1'b0, 8'h30, 8'h00);
        wait_dones("rr_dones", 6, 60);
        tick();
        req_d[0] = 1'b0;
        req_d[1] = 1'b0;
        check("rr_drained", 32'(exp_q0.size() + exp_q1.size() + exp_win_q.size()), 0);

        // fixed priority: requester 1 starves
        avr_write(CTRL_A, 8'h03);
        for (int k = 0; k < 4; k++) begin
            exp_q0.push_back(make_exp(1'b0, 8'h10, 8'h00));
            exp_win_q.push_back(1'b0);
        end
        req_d[0] = 1'b1;
        req_d[1] = 1'b1;
        wait_dones("pri_dones", 4, 50);
        tick();
        req_d[0] = 1'b0;
        req_d[1] = 1'b0;
        check("pri_drained", 32'(exp_q0.size() + exp_win_q.size()), 0);

        // AVR traffic holds off requester 0 for 20 cycles
        avr_write(CTRL_A, 8'h01);
        exp_q0.push_back(make_exp(1'b1, 8'h41, 8'h77));
        exp_win_q.push_back(1'b0);
        set_req(0, 1'b1, 1'b1, 8'h41, 8'h77);
        for (int k = 0; k <= 20; k++) begin
            dm_sel = 1'b1;
            ramadr = 8'(8'h80 + k);
            ramwe  = k[0];
            ramre  = !k[0];
            dbus_in = 8'($urandom_range(255, 0));
            if (k[0]) ref_mem[ramadr] = dbus_in;
            @(negedge clk);
            check("stv_fwd_adr", 32'(xif.tgt_adr), 32'(8'h80 + k));
            check("stv_fwd_we_re", 32'({xif.tgt_we, xif.tgt_re}), 32'({k[0], !k[0]}));
            if (!k[0]) check("stv_fwd_rdata", 32'(dbus_out), 32'(ref_mem[ramadr]));
            check("stv_no_done", 32'(xif.done), 0);
            if (k >= 1) check("stv_gnt", 32'(xif.gnt), 32'h1);
            tick();
        end
        clken = 1'b0;
        avr_read_chk("stv_stat", STAT_A, 8'hF5);
        clken = 1'b1;
        @(negedge clk);
        check("stv_issue", 32'({xif.tgt_we, xif.tgt_adr}), 32'h141);
        wait_dones("stv_done", 1, 5);
        tick();
        req_d[0] = 1'b0;
        avr_read_chk("stv_stat_after", STAT_A, 8'h04);
        avr_write(CTRL_A, 8'h01);
        avr_read_chk("stv_stat_clr", STAT_A, 8'h00);

        // STAT read in BUSY does not block the hardware issue
        exp_q0.push_back(make_exp(1'b0, 8'h42, 8'h00));
        exp_win_q.push_back(1'b0);
        set_req(0, 1'b1, 1'b0, 8'h42, 8'h00);
        tick();
        dm_sel = 1'b1;
        ramre  = 1'b1;
        ramadr = STAT_A;
        @(negedge clk);
        check("st38_oen", 32'(io_out_en), 1);
        check("st38_busy", 32'(dbus_out[0]), 1);
        check("st38_issue", 32'({xif.tgt_we, xif.tgt_re, xif.tgt_adr}), 32'h142);
        tick();
        avr_idle();
        wait_dones("st38_done", 1, 5);
        tick();
        req_d[0] = 1'b0;

        // reset while a write is parked in BUSY
        clken = 1'b0;
        set_req(0, 1'b1, 1'b1, 8'h43, 8'h99);
        tick();
        @(negedge clk);
        check("rb_gnt", 32'(xif.gnt), 32'h1);
        check("rb_state", 32'(state_dbg), 32'h1);
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        clken = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rb_gnt_off", 32'(xif.gnt), 0);
            check("rb_no_done", 32'(xif.done), 0);
            check("rb_no_strobe", 32'({xif.tgt_we, xif.tgt_re}), 0);
            check("rb_idle", 32'(state_dbg), 0);
            tick();
        end
        avr_read_chk("rb_ctrl", CTRL_A, 8'h00);
        avr_read_chk("rb_stat", STAT_A, 8'h02);
        req_d[0] = 1'b0;
        check("rb_mem_kept", 32'(tmem[8'h43]), 32'(ref_mem[8'h43]));

        // randomized traffic
        avr_write(CTRL_A, 8'h01);
        ctrl_model = 8'h01;
        fork
            begin
                fork
                    req_driver(0, 25);
                    req_driver(1, 25);
                join
                stop = 1;
            end
            avr_random();
        join
        clken = 1'b1;
        repeat (4) tick();
        check("final_q0_empty", 32'(exp_q0.size()), 0);
        check("final_q1_empty", 32'(exp_q1.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
